hsv_core_issue_regread: RTL and testbench
=========================================

# hsv_core_issue_regread

Register-read and scoreboard stage directly upstream of the issue muxing stage. Accepts one decoded instruction per cycle, reads rs1/rs2 from the 32×32 integer register file, and tracks pending destination writes in a busy scoreboard. Holds the instruction on RAW or WAW hazards, and presents registered operands, masks and payload to issue muxing. Writeback commits update the register file and release scoreboard bits.

## Interface
- XLEN, 32, register/data width (package `word`)
- NUM_REGS, 32, architectural registers; x0 hardwired zero
- clk_core  in  1  core clock; all state on rising edge
- rst_core  in  1  synchronous, active-high reset
- valid_i  in  1  decoded instruction present
- ready_o  out  1  stage can accept this cycle
- issue_data_i  in  issue_data_t  decoded payload, passed through
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_used, rs2_used  in  1 each  source actually read by the instruction
- rd_addr  in  5  destination index
- rd_write  in  1  instruction writes rd
- stall  in  1  issue muxing cannot take the output register
- flush_req  in  1  discard the held and incoming instruction
- commit_valid  in  1  writeback this cycle
- commit_addr  in  5  writeback destination
- commit_data  in  XLEN  writeback value
- valid_o  out  1  output register holds an instruction
- issue_data_o  out  issue_data_t  registered payload
- rs1_data, rs2_data  out  XLEN each  registered operands
- mask  out  reg_mask  one-hot of used sources (bit 0 never set)
- rd_mask  out  reg_mask  one-hot of rd if rd_write and rd≠0, else 0
- hazard  out  1  combinational: valid_i blocked by scoreboard

## Operation
- Scoreboard `busy[31:0]`, with bit 0 always 0.
- Conflict definition:
  - rs1 conflicts if rs1_used & busy[rs1_addr] & ~(commit_valid & commit_addr==rs1_addr).
  - rs2 conflicts by the same rule.
  - rd conflicts (WAW) if rd_write & busy[rd_addr] & not cleared by a same-cycle commit.
- hazard = valid_i & any conflict.
- ready_o = (~valid_o | ~stall) & ~flush_req.
- accept = valid_i & ready_o & ~hazard.
- On accept:
  - Output register loads the payload, operands, masks, and valid_o=1.
  - busy[rd_addr] is set if rd_write & rd≠0.
- Output handoff: if valid_o & ~stall & ~accept, valid_o clears. If stall, all outputs hold unchanged.
- Operand read:
  - Index 0 returns 0.
  - If commit_valid & commit_addr==rsN_addr ≠ 0, returns commit_data (write-through bypass).
  - Otherwise returns the register file value.
- Commit:
  - commit_valid & commit_addr≠0 writes the register file and clears busy[commit_addr].
  - If a same-cycle accept sets the same bit, set wins.
- Flush (flush_req):
  - valid_o←0 and no accept.
  - The busy bit named by rd_mask of the held instruction (if valid_o) is cleared, because it never reached execution.
  - Same-cycle commit still applies.
- Reset clears busy, valid_o, rs1_data, rs2_data, mask, rd_mask and issue_data_o to 0. Register file contents are not reset.
- Reset mid-stall drops the held instruction; the following cycle behaves as post-reset.

## Timing
- Latency of 1 cycle: accept at edge N gives valid_o high after edge N.
- Full throughput (1 instruction/cycle) when there is no hazard and no stall.
- Commit at edge N is visible to a dependent instruction presented in the same cycle, via bypass. hazard is low that cycle.
- A back-to-back dependent instruction (producer accepted at N) sees hazard until its commit cycle.
- ready_o and hazard are combinational. All other outputs are registered.
- flush_req has priority over accept and stall.
- Reset has priority over everything.

## Structure
- Shared package hsv_core_pkg holds:
  - `word`, `reg_mask`, `reg_addr` (logic[4:0]), `issue_data_t`;
  - a constant `REG_ZERO=5'd0`.
- Sub-module hsv_core_issue_scoreboard:
  - Contains the busy vector, set/clear/flush logic and conflict outputs.
  - Register file array and bypass stay in the top.

## Test plan
- Reset, then commit x5=0xDEADBEEF and present rs1=5 → rs1_data=0xDEADBEEF one cycle after accept; valid_o=1.
- Accept writer rd=7, then present a reader with rs2=7 → hazard=1 and ready-but-not-accepted until commit x7=0x1234. In the commit cycle hazard=0 and rs2_data=0x1234 (bypass).
- Hold stall=1 for 3 cycles with valid_o=1 → outputs unchanged, ready_o=0. Release → next instruction accepted the same cycle.
- Held instruction with rd=9 and flush_req=1 → valid_o=0 and busy[9]=0. A following reader of x9 issues without hazard.
- rd=0 writer, then reader of x0 → no busy bit set, rs1_data=0. Commit to x0 of 0xFFFFFFFF → x0 still reads 0.
- Accept writer rd=3 while commit_addr=3 in the same cycle → busy[3] remains 1. A subsequent reader of x3 sees hazard=1.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared core types, register-file constants and mask helper
package hsv_core_pkg;

    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;

    typedef logic [XLEN-1:0] word;
    typedef logic [NUM_REGS-1:0] reg_mask;
    typedef logic [4:0] reg_addr;

    localparam reg_addr REG_ZERO = 5'd0;

    typedef struct packed {
        word pc;
        word imm;
        logic [7:0] op;
    } issue_data_t;

    // One-hot of a register index; x0 never appears in a mask
    function automatic reg_mask reg_onehot(input reg_addr a, input logic en);
        reg_onehot = (en && a != REG_ZERO) ? reg_mask'(1) << a : '0;
    endfunction

endpackage

// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard: busy bits for pending destination writes and RAW/WAW conflict detection
module hsv_core_issue_scoreboard
    import hsv_core_pkg::*;
(
    input  logic    clk_core,
    input  logic    rst_core,
    input  reg_addr rs1_addr,
    input  logic    rs1_used,
    input  reg_addr rs2_addr,
    input  logic    rs2_used,
    input  reg_addr rd_addr,
    input  logic    rd_write,
    input  logic    commit_valid,
    input  reg_addr commit_addr,
    input  logic    accept,
    input  reg_mask flush_mask,
    output logic    conflict
);

    reg_mask busy;
    reg_mask set_mask;
    reg_mask clr_mask;
    logic    rs1_hit;
    logic    rs2_hit;
    logic    rd_hit;

    // A same-cycle commit to a source or destination releases it before the check
    assign rs1_hit = rs1_used & busy[rs1_addr] & ~(commit_valid && commit_addr == rs1_addr);
    assign rs2_hit = rs2_used & busy[rs2_addr] & ~(commit_valid && commit_addr == rs2_addr);
    assign rd_hit  = rd_write & busy[rd_addr] & ~(commit_valid && commit_addr == rd_addr);
    assign conflict = rs1_hit | rs2_hit | rd_hit;

    // Bits set by the accepted instruction and cleared by commit or by flushing the held writer
    always_comb begin
        set_mask = accept ? reg_onehot(rd_addr, rd_write) : '0;
        clr_mask = reg_onehot(commit_addr, commit_valid) | flush_mask;
    end

    // Set wins over a same-cycle clear; bit 0 stays zero
    always_ff @(posedge clk_core) begin
        if (rst_core) busy <= '0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~reg_mask'(1);
    end

endmodule

// File: rtl/hsv_core_issue_regread.sv
// hsv_core_issue_regread: register read, hazard hold and output register feeding issue muxing
module hsv_core_issue_regread
    import hsv_core_pkg::*;
(
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        valid_i,
    output logic        ready_o,
    input  issue_data_t issue_data_i,
    input  reg_addr     rs1_addr,
    input  reg_addr     rs2_addr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  reg_addr     rd_addr,
    input  logic        rd_write,
    input  logic        stall,
    input  logic        flush_req,
    input  logic        commit_valid,
    input  reg_addr     commit_addr,
    input  word         commit_data,
    output logic        valid_o,
    output issue_data_t issue_data_o,
    output word         rs1_data,
    output word         rs2_data,
    output reg_mask     mask,
    output reg_mask     rd_mask,
    output logic        hazard
);

    word     rf [NUM_REGS];
    logic    conflict;
    logic    accept;
    reg_mask flush_mask;

    function automatic word read_op(input reg_addr a);
        read_op = (a == REG_ZERO) ? '0 :
                  (commit_valid && commit_addr == a) ? commit_data : rf[a];
    endfunction

    assign ready_o    = (~valid_o | ~stall) & ~flush_req;
    assign hazard     = valid_i & conflict;
    assign accept     = valid_i & ready_o & ~conflict;
    assign flush_mask = (flush_req & valid_o) ? rd_mask : '0;

    hsv_core_issue_scoreboard u_scoreboard (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .rs1_addr     (rs1_addr),
        .rs1_used     (rs1_used),
        .rs2_addr     (rs2_addr),
        .rs2_used     (rs2_used),
        .rd_addr      (rd_addr),
        .rd_write     (rd_write),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .accept       (accept),
        .flush_mask   (flush_mask),
        .conflict     (conflict)
    );

    // Writeback into the register file; x0 is never stored and contents survive reset
    always_ff @(posedge clk_core) begin
        if (commit_valid && commit_addr != REG_ZERO) rf[commit_addr] <= commit_data;
    end

    // Output register: flush drops, accept loads, stall holds, otherwise the slot drains
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            valid_o      <= 1'b0;
            issue_data_o <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            mask         <= '0;
            rd_mask      <= '0;
        end else if (flush_req) begin
            valid_o <= 1'b0;
        end else if (accept) begin
            valid_o      <= 1'b1;
            issue_data_o <= issue_data_i;
            rs1_data     <= rs1_used ? read_op(rs1_addr) : '0;
            rs2_data     <= rs2_used ? read_op(rs2_addr) : '0;
            mask         <= reg_onehot(rs1_addr, rs1_used) | reg_onehot(rs2_addr, rs2_used);
            rd_mask      <= reg_onehot(rd_addr, rd_write);
        end else if (!stall) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hsv_core_issue_regread.sv
// tb_hsv_core_issue_regread: directed vectors with a queue scoreboard and output monitor
module tb_hsv_core_issue_regread;
    import hsv_core_pkg::*;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        valid_i;
    logic        ready_o;
    issue_data_t issue_data_i;
    reg_addr     rs1_addr, rs2_addr, rd_addr, commit_addr;
    logic        rs1_used, rs2_used, rd_write;
    logic        stall, flush_req, commit_valid;
    word         commit_data;
    logic        valid_o;
    issue_data_t issue_data_o;
    word         rs1_data, rs2_data;
    reg_mask     mask, rd_mask;
    logic        hazard;

    typedef struct {
        word         r1;
        word         r2;
        reg_mask     m;
        reg_mask     rm;
        issue_data_t d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    hsv_core_issue_regread dut (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .issue_data_i (issue_data_i),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rd_addr      (rd_addr),
        .rd_write     (rd_write),
        .stall        (stall),
        .flush_req    (flush_req),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .valid_o      (valid_o),
        .issue_data_o (issue_data_o),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .mask         (mask),
        .rd_mask      (rd_mask),
        .hazard       (hazard)
    );

    always #5 clk_core = ~clk_core;

    function automatic reg_mask m(input int a);
        m = reg_mask'(1) << a;
    endfunction

    task automatic chk(input string n, input logic [79:0] act, input logic [79:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", n, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle();
        valid_i = 0; rs1_used = 0; rs2_used = 0; rd_write = 0;
        commit_valid = 0; flush_req = 0; stall = 0;
    endtask

    task automatic instr(input int a1, input logic u1, input int a2, input logic u2,
                         input int d, input logic w, input logic [7:0] tag);
        valid_i = 1;
        rs1_addr = reg_addr'(a1); rs1_used = u1;
        rs2_addr = reg_addr'(a2); rs2_used = u2;
        rd_addr = reg_addr'(d); rd_write = w;
        issue_data_i = '{pc: 32'h1000 + 32'(tag), imm: ~32'(tag), op: tag};
    endtask

    task automatic commit(input int a, input word v);
        commit_valid = 1; commit_addr = reg_addr'(a); commit_data = v;
    endtask

    task automatic push(input word r1, input word r2, input reg_mask mm, input reg_mask rm);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.m = mm; e.rm = rm; e.d = issue_data_i;
        exp_q.push_back(e);
    endtask

    // Monitor: an instruction is handed to issue muxing when valid_o is high and stall is low
    always @(negedge clk_core) begin
        if (!rst_core && valid_o && !stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {79'b0, valid_o}, 80'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rs1_data", 80'(rs1_data), 80'(e.r1));
                chk("rs2_data", 80'(rs2_data), 80'(e.r2));
                chk("mask", 80'(mask), 80'(e.m));
                chk("rd_mask", 80'(rd_mask), 80'(e.rm));
                chk("issue_data", 80'(issue_data_o), 80'(e.d));
            end
        end
    end

    initial begin
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0; commit_addr = 0; commit_data = 0;
        issue_data_i = '0;
        idle();
        rst_core = 1;
        step(); step();
        rst_core = 0;
        #1;
        chk("rst_valid_o", 80'(valid_o), 80'd0);
        chk("rst_rs1_data", 80'(rs1_data), 80'd0);
        chk("rst_rs2_data", 80'(rs2_data), 80'd0);
        chk("rst_mask", 80'(mask), 80'd0);
        chk("rst_rd_mask", 80'(rd_mask), 80'd0);
        chk("rst_issue_data", 80'(issue_data_o), 80'd0);
        chk("rst_ready", 80'(ready_o), 80'd1);
        commit(9, 32'h909); step();
        commit(3, 32'h333); step();
        idle();
        // commit x5 and read it through the bypass in the same cycle
        commit(5, 32'hDEADBEEF); instr(5, 1, 0, 0, 0, 0, 1);
        #1;
        chk("t1_hazard", 80'(hazard), 80'd0);
        chk("t1_ready", 80'(ready_o), 80'd1);
        push(32'hDEADBEEF, 0, m(5), 0);
        step(); idle();
        chk("t1_valid_o", 80'(valid_o), 80'd1);
        // writer x7 then dependent reader held until commit
        instr(5, 1, 0, 0, 7, 1, 2);
        #1;
        chk("t2_w_hazard", 80'(hazard), 80'd0);
        push(32'hDEADBEEF, 0, m(5), m(7));
        step();
        instr(0, 0, 7, 1, 0, 0, 3);
        #1;
        chk("t2_raw_hazard", 80'(hazard), 80'd1);
        chk("t2_raw_ready", 80'(ready_o), 80'd1);
        step();
        #1;
        chk("t2_raw_hazard2", 80'(hazard), 80'd1);
        chk("t2_not_accepted", 80'(valid_o), 80'd0);
        step();
        commit(7, 32'h1234);
        #1;
        chk("t2_commit_hazard", 80'(hazard), 80'd0);
        push(0, 32'h1234, m(7), 0);
        step(); idle();
        // stall holds the output and blocks the next instruction
        instr(7, 1, 0, 0, 0, 0, 4);
        #1;
        chk("t3_hazard", 80'(hazard), 80'd0);
        push(32'h1234, 0, m(7), 0);
        step();
        stall = 1;
        instr(5, 1, 0, 0, 0, 0, 5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_ready", 80'(ready_o), 80'd0);
            chk("t3_stall_valid", 80'(valid_o), 80'd1);
            chk("t3_stall_rs1", 80'(rs1_data), 80'h1234);
            chk("t3_stall_op", 80'(issue_data_o.op), 80'd4);
            step();
        end
        stall = 0;
        #1;
        chk("t3_release_ready", 80'(ready_o), 80'd1);
        chk("t3_release_hazard", 80'(hazard), 80'd0);
        push(32'hDEADBEEF, 0, m(5), 0);
        step(); idle();
        // flush a held writer of x9; a reader of x9 then issues freely
        instr(0, 0, 0, 0, 9, 1, 6);
        #1;
        chk("t4_hazard", 80'(hazard), 80'd0);
        push(0, 0, 0, m(9));
        step();
        flush_req = 1;
        instr(0, 0, 0, 0, 10, 1, 7);
        #1;
        chk("t4_flush_ready", 80'(ready_o), 80'd0);
        step(); idle();
        #1;
        chk("t4_flush_valid", 80'(valid_o), 80'd0);
        instr(9, 1, 0, 0, 0, 0, 8);
        #1;
        chk("t4_reader_hazard", 80'(hazard), 80'd0);
        push(32'h909, 0, m(9), 0);
        step(); idle();
        // x0 is never busy and always reads zero
        instr(0, 1, 0, 0, 0, 1, 9);
        #1;
        chk("t5_w0_hazard", 80'(hazard), 80'd0);
        push(0, 0, 0, 0);
        step();
        commit(0, 32'hFFFFFFFF);
        instr(0, 1, 0, 1, 0, 0, 10);
        #1;
        chk("t5_r0_hazard", 80'(hazard), 80'd0);
        push(0, 0, 0, 0);
        step(); idle();
        instr(0, 1, 0, 1, 0, 0, 11);
        push(0, 0, 0, 0);
        step(); idle();
        // accept of writer x3 beats the same-cycle commit clear
        commit(3, 32'h777);
        instr(0, 0, 0, 0, 3, 1, 12);
        #1;
        chk("t6_w_hazard", 80'(hazard), 80'd0);
        push(0, 0, 0, m(3));
        step(); idle();
        instr(3, 1, 0, 0, 0, 0, 13);
        #1;
        chk("t6_raw_hazard", 80'(hazard), 80'd1);
        step();
        #1;
        chk("t6_raw_hazard2", 80'(hazard), 80'd1);
        step();
        commit(3, 32'hABC);
        #1;
        chk("t6_commit_hazard", 80'(hazard), 80'd0);
        push(32'hABC, 0, m(3), 0);
        step(); idle();
        step(); step();
        // reset while stalled drops the held writer and its busy bit
        instr(0, 0, 0, 0, 12, 1, 14);
        push(0, 0, 0, m(12));
        step(); idle();
        stall = 1;
        step();
        rst_core = 1;
        step();
        rst_core = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        #1;
        chk("t7_valid_o", 80'(valid_o), 80'd0);
        chk("t7_rd_mask", 80'(rd_mask), 80'd0);
        chk("t7_issue_data", 80'(issue_data_o), 80'd0);
        stall = 0;
        instr(0, 0, 0, 0, 12, 1, 15);
        #1;
        chk("t7_waw_hazard", 80'(hazard), 80'd0);
        push(0, 0, 0, m(12));
        step(); idle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        step(); step();
        chk("drain", 80'(exp_q.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
